seq_div_12: RTL

- Sequential restoring divider; the inverse operation of the 12x12 Dadda multiplier.
- Takes a 2W-bit dividend (a product-width value) and a W-bit divisor, one quotient bit per cycle.
- Returns quotient and remainder with a start/busy/done handshake.
- Used to recover operands from multiplier results and as a self-check companion in the multiplier test environment.

---
 rtl/seq_div_12_pkg.sv | 14 +
 rtl/seq_div_12_step.sv | 23 ++
 rtl/seq_div_12.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_div_12_pkg.sv
// Shared constants and state encoding for the seq_div_12 restoring divider.
package seq_div_pkg;

    localparam int unsigned W  = 12;
    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_12_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned W = 12
) (
    input  logic [W:0]   pr,
    input  logic         din,
    input  logic [W-1:0] divisor,
    output logic [W:0]   pr_next,
    output logic         q_bit
);

    logic [W+1:0] pr_ext;
    logic [W+1:0] dsr_ext;

    // One guard bit above pr keeps the compare exact; the result always fits W+1 bits.
    always_comb begin
        pr_ext  = {pr, din};
        dsr_ext = (W + 2)'(divisor);
        q_bit   = (pr_ext >= dsr_ext);
        pr_next = (W + 1)'(q_bit ? (pr_ext - dsr_ext) : pr_ext);
    end

endmodule

// File: rtl/seq_div_12.sv
// Sequential restoring divider: DW-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional SEQ_DIV_EARLY_TERM_EN: finish in one cycle when dividend < divisor.
module seq_div_12 #(
    parameter  int unsigned W  = seq_div_pkg::W,
    localparam int unsigned DW = 2 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [W-1:0]  remainder,
    output logic          div_by_zero
);

    import seq_div_pkg::*;

    localparam int unsigned CNT_W = $clog2(DW);

    state_t           state;
    state_t           state_next;
    logic [DW-1:0]    dvd;
    logic [DW-1:0]    quo;
    logic [W-1:0]     dsr;
    logic [W:0]       pr;
    logic [W:0]       pr_next;
    logic             q_bit;
    logic [CNT_W-1:0] cnt;

    div_step #(.W(W)) u_step (
        .pr      (pr),
        .din     (dvd[DW-1]),
        .divisor (dsr),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            quo         <= '0;
            dsr         <= '0;
            pr          <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[W-1:0];
                            div_by_zero <= 1'b1;
                        end
`ifdef SEQ_DIV_EARLY_TERM_EN
                        else if (dividend < DW'(divisor)) begin
                            quotient    <= '0;
                            remainder   <= dividend[W-1:0];
                            div_by_zero <= 1'b0;
                        end
`endif
                        else begin
                            dvd <= dividend;
                            dsr <= divisor;
                            pr  <= '0;
                            quo <= '0;
                            cnt <= CNT_W'(DW - 1);
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[DW-2:0], 1'b0};
                    quo <= {quo[DW-2:0], q_bit};
                    pr  <= pr_next;
                    cnt <= cnt - 1'b1;
                    // Results are loaded on the last step so they are visible in the FIN cycle.
                    if (cnt == '0) begin
                        quotient    <= {quo[DW-2:0], q_bit};
                        remainder   <= pr_next[W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_next = FIN;
                    end
`ifdef SEQ_DIV_EARLY_TERM_EN
                    else if (dividend < DW'(divisor)) begin
                        state_next = FIN;
                    end
`endif
                    else begin
                        state_next = RUN;
                    end
                end
            end
            RUN:     if (cnt == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

endmodule
